// File: rtl/wbtx_pkg.sv
// Shared types and constants for the write-back UART monitor.
// The transmitter emits each 16-bit word as two 8N1 frames, low byte first.
package wbtx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned BYTES_PER_WORD = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o always presents the head entry.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Write-back monitor: buffers every register write and serialises it on an 8N1 UART line,
// low byte first. Writes that find the FIFO full are dropped and raise a sticky ovf flag.
module wb_uart_tx
    import wbtx_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CLKDIV = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [W-1:0]               rwd_i,
    output logic                       txd_o,
    output logic                       busy_o,
    output logic                       ovf_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o
);

    localparam int unsigned BW = $clog2(CLKDIV);
    localparam int unsigned IW = $clog2(BITS_PER_BYTE);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    tx_state_t               state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    hi_q, hi_d;
    logic [W-1:0]            shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    ovf_q, ovf_d;

    logic                    pop;
    logic                    baud_wrap;
    logic [IW-1:0]           idx_next;
    logic [BITS_PER_BYTE-1:0] cur_byte;
    logic [W-1:0]            fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_cnt;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (we_i),
        .pop_i   (pop),
        .wdata_i (rwd_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign baud_wrap = (baud_q == BW'(CLKDIV - 1));
    assign idx_next  = idx_q + 1'b1;
    assign cur_byte  = hi_q ? shift_q[(BYTES_PER_WORD-1)*BITS_PER_BYTE +: BITS_PER_BYTE]
                            : shift_q[BITS_PER_BYTE-1:0];

    // txd_d is the line level for the state being entered, so txd_q changes with the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_wrap ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        hi_d    = hi_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    hi_d    = 1'b0;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    idx_d   = '0;
                    txd_d   = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (idx_q == IW'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_next;
                        txd_d = cur_byte[idx_next];
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (!hi_q) begin
                        hi_d    = 1'b1;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // A pop on the same edge frees a slot, so only a write with no pop can be lost.
    assign ovf_d = ovf_q | (we_i & fifo_full & ~pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            hi_q    <= 1'b0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign txd_o      = txd_q;
    assign ovf_o      = ovf_q;
    assign fifo_cnt_o = fifo_cnt;
    assign busy_o     = (state_q != IDLE) | (fifo_cnt != '0);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: a line receiver plus a queue model of the FIFO and frame timing.
// Two instances share clock and reset: one at CLKDIV=4, one at CLKDIV=2.
module tb_wb_uart_tx;

    localparam int DEPTH = 8;
    localparam int CD0   = 4;
    localparam int CD1   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1;
    logic [15:0] rwd0, rwd1;
    logic        txd0, txd1, busy0, busy1, ovf0, ovf1;
    logic [3:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    wb_uart_tx #(.W(16), .DEPTH(DEPTH), .CLKDIV(CD0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we0), .rwd_i(rwd0),
        .txd_o(txd0), .busy_o(busy0), .ovf_o(ovf0), .fifo_cnt_o(cnt0)
    );

    wb_uart_tx #(.W(16), .DEPTH(DEPTH), .CLKDIV(CD1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we1), .rwd_i(rwd1),
        .txd_o(txd1), .busy_o(busy1), .ovf_o(ovf1), .fifo_cnt_o(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: words waiting, words accepted in order, edge at which the line is free again.
    logic [15:0] m_q[$];
    logic [15:0] m_acc[$];
    int          m_idle, m_k, m_cd;
    logic        m_ovf;

    logic [15:0] rx_words[$];
    int          rx_glitch;

    function automatic void model_reset(input int cd);
        m_q.delete();
        m_acc.delete();
        m_idle = 0;
        m_k    = 0;
        m_cd   = cd;
        m_ovf  = 1'b0;
    endfunction

    function automatic bit model_pop_now();
        return (m_k >= m_idle) && (m_q.size() > 0);
    endfunction

    function automatic void model_step(input logic we, input logic [15:0] d);
        bit pop;
        bit full_pre;
        pop      = model_pop_now();
        full_pre = (m_q.size() == DEPTH);
        if (pop) begin
            void'(m_q.pop_front());
            m_idle = m_k + 20 * m_cd + 1;
        end
        if (we) begin
            if (full_pre && !pop) begin
                m_ovf = 1'b1;
            end else begin
                m_q.push_back(d);
                m_acc.push_back(d);
            end
        end
        m_k++;
    endfunction

    // Line level of bit slot b (0..19) of a word: start, 8 data LSB first, stop, twice.
    function automatic logic frame_bit(input logic [15:0] w, input int b);
        logic [7:0] by;
        int         pos;
        by  = (b < 10) ? w[7:0] : w[15:8];
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    function logic get_txd(input int sel);
        return (sel == 0) ? txd0 : txd1;
    endfunction

    // Waits for a start bit, records 20 bit times plus one trailing cycle, decodes mid-bit.
    task automatic rx_frame(input int sel, input int budget, output int waited,
                            output logic [15:0] w, output int glitches);
        int   cd;
        logic samp [0:80];
        logic ex;
        cd       = (sel == 0) ? CD0 : CD1;
        waited   = 0;
        w        = '0;
        glitches = 0;
        while (get_txd(sel) === 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= budget) return;
        for (int i = 0; i <= 20 * cd; i++) begin
            samp[i] = get_txd(sel);
            if (i < 20 * cd) @(negedge clk);
        end
        for (int b = 0; b < 20; b++) begin
            if ((b % 10) >= 1 && (b % 10) <= 8) begin
                w[(b / 10) * 8 + (b % 10) - 1] = samp[b * cd + cd / 2];
            end
        end
        for (int i = 0; i <= 20 * cd; i++) begin
            ex = (i == 20 * cd) ? 1'b1 : frame_bit(w, i / cd);
            if (samp[i] !== ex) glitches++;
        end
    endtask

    task automatic receive_all(input int sel, input int idle_budget);
        int          waited, gl;
        logic [15:0] w;
        forever begin
            rx_frame(sel, idle_budget, waited, w, gl);
            if (waited >= idle_budget) break;
            rx_words.push_back(w);
            rx_glitch += gl;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we0   = 1'b0;
        we1   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_words.delete();
        rx_glitch = 0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        we0 = 1'b0; we1 = 1'b0; rwd0 = '0; rwd1 = '0;
        @(negedge clk);
        n_checks++;
        if (txd0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 4'd0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: txd=%b busy=%b cnt=%0d ovf=%b, want 1 0 0 0",
                     txd0, busy0, cnt0, ovf0);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0 || txd1 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_idle_line: %0d bad cycles, want 0", bad); end
        n_checks++;
        if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
        n_checks++;
        if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    endtask

    task automatic test_single();
        int          waited, gl;
        logic [15:0] w;
        do_reset();
        we0 = 1'b1; rwd0 = 16'hA55A;
        @(negedge clk);
        we0 = 1'b0;
        n_checks++;
        if (cnt0 !== 4'd1 || txd0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_write: cnt=%0d txd=%b busy=%b, want 1 1 1",
                     cnt0, txd0, busy0);
        end
        rx_frame(0, 10, waited, w, gl);
        n_checks++;
        if (waited !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", waited); end
        n_checks++;
        if (w !== 16'hA55A) begin n_fail++; $display("FAIL single_data: got %h want a55a", w); end
        n_checks++;
        if (gl !== 0) begin n_fail++; $display("FAIL single_waveform: %0d bad cycles want 0", gl); end
        n_checks++;
        if (busy0 !== 1'b0 || cnt0 !== 4'd0) begin
            n_fail++;
            $display("FAIL single_done: busy=%b cnt=%0d want 0 0", busy0, cnt0);
        end
    endtask

    task automatic test_overflow();
        int cnt_err, ovf_err, peak, bad;
        do_reset();
        model_reset(CD0);
        cnt_err = 0; ovf_err = 0; peak = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    we0  = 1'b1;
                    rwd0 = 16'(k + 1);
                    model_step(we0, rwd0);
                    @(negedge clk);
                    if (int'(cnt0) != m_q.size()) cnt_err++;
                    if (ovf0 !== m_ovf) ovf_err++;
                    if (int'(cnt0) > peak) peak = int'(cnt0);
                end
                we0 = 1'b0;
            end
            receive_all(0, 30 * CD0);
        join
        n_checks++;
        if (cnt_err !== 0 || ovf_err !== 0) begin
            n_fail++;
            $display("FAIL ovf_track: cnt errs %0d ovf errs %0d want 0 0", cnt_err, ovf_err);
        end
        n_checks++;
        if (peak !== DEPTH) begin n_fail++; $display("FAIL ovf_peak: got %0d want %0d", peak, DEPTH); end
        n_checks++;
        if (rx_words.size() !== 9) begin
            n_fail++;
            $display("FAIL ovf_rx_count: got %0d want 9", rx_words.size());
        end
        bad = 0;
        foreach (rx_words[i]) if (rx_words[i] !== 16'(i + 1)) bad++;
        n_checks++;
        if (bad !== 0 || rx_glitch !== 0) begin
            n_fail++;
            $display("FAIL ovf_rx_order: %0d wrong words %0d glitches want 0 0", bad, rx_glitch);
        end
        n_checks++;
        if (ovf0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b want 1 0", ovf0, busy0);
        end
    endtask

    task automatic test_full_pop();
        int          cnt_err, ovf_err, cnt_after, bad;
        bit          done;
        logic [15:0] exp[$];
        do_reset();
        model_reset(CD0);
        cnt_err = 0; ovf_err = 0; cnt_after = -1; done = 1'b0;
        fork
            begin
                for (int k = 0; k < 400 && !done; k++) begin
                    if (k < 9) begin
                        we0 = 1'b1; rwd0 = 16'(k + 1);
                    end else if (model_pop_now() && m_q.size() == DEPTH) begin
                        we0 = 1'b1; rwd0 = 16'h00FF; done = 1'b1;
                    end else begin
                        we0 = 1'b0;
                    end
                    model_step(we0, rwd0);
                    @(negedge clk);
                    if (int'(cnt0) != m_q.size()) cnt_err++;
                    if (ovf0 !== 1'b0) ovf_err++;
                    cnt_after = int'(cnt0);
                end
                we0 = 1'b0;
            end
            receive_all(0, 30 * CD0);
        join
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL fullpop_reach: no full+pop edge found"); end
        n_checks++;
        if (cnt_after !== DEPTH) begin
            n_fail++;
            $display("FAIL fullpop_cnt: got %0d want %0d", cnt_after, DEPTH);
        end
        n_checks++;
        if (cnt_err !== 0 || ovf_err !== 0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_track: cnt errs %0d ovf errs %0d ovf=%b want 0 0 0",
                     cnt_err, ovf_err, ovf0);
        end
        for (int i = 1; i <= 9; i++) exp.push_back(16'(i));
        exp.push_back(16'h00FF);
        bad = (rx_words.size() == exp.size()) ? 0 : 1000;
        foreach (rx_words[i]) if (i < exp.size() && rx_words[i] !== exp[i]) bad++;
        n_checks++;
        if (bad !== 0 || rx_glitch !== 0) begin
            n_fail++;
            $display("FAIL fullpop_rx: %0d errs (%0d words) %0d glitches want 0 (10) 0",
                     bad, rx_words.size(), rx_glitch);
        end
    endtask

    task automatic test_reset_midframe();
        int          waited, gl;
        logic [15:0] w;
        do_reset();
        // High bytes of zero make the line low during the high-byte data bits.
        for (int k = 0; k < 4; k++) begin
            we0 = 1'b1; rwd0 = {8'h00, 8'($urandom_range(1, 255))};
            @(negedge clk);
        end
        we0 = 1'b0;
        repeat (58) @(negedge clk);
        n_checks++;
        if (cnt0 !== 4'd3 || txd0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_pre: cnt=%0d txd=%b want 3 0", cnt0, txd0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (txd0 !== 1'b1 || cnt0 !== 4'd0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_abort: txd=%b cnt=%0d busy=%b want 1 0 0", txd0, cnt0, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        we0 = 1'b1; rwd0 = 16'h1234;
        @(negedge clk);
        we0 = 1'b0;
        rx_frame(0, 10, waited, w, gl);
        n_checks++;
        if (waited !== 1 || w !== 16'h1234 || gl !== 0) begin
            n_fail++;
            $display("FAIL midframe_after: wait=%0d data=%h glitches=%0d want 1 1234 0",
                     waited, w, gl);
        end
    endtask

    task automatic test_spaced();
        int          waited, gl, idle_bad;
        logic [15:0] w, d;
        do_reset();
        idle_bad = 0;
        for (int n = 0; n < 3; n++) begin
            d   = 16'($urandom);
            we1 = 1'b1; rwd1 = d;
            @(negedge clk);
            we1 = 1'b0;
            rx_frame(1, 10, waited, w, gl);
            n_checks++;
            if (waited !== 1) begin n_fail++; $display("FAIL spaced_latency: got %0d want 1", waited); end
            n_checks++;
            if (w !== d) begin n_fail++; $display("FAIL spaced_data: got %h want %h", w, d); end
            n_checks++;
            if (gl !== 0 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL spaced_frame: glitches=%0d busy=%b want 0 0", gl, busy1);
            end
            repeat (158) begin
                @(negedge clk);
                if (txd1 !== 1'b1 || busy1 !== 1'b0) idle_bad++;
            end
        end
        n_checks++;
        if (idle_bad !== 0) begin n_fail++; $display("FAIL spaced_idle: %0d bad cycles want 0", idle_bad); end
    endtask

    task automatic test_random();
        int cnt_err, ovf_err, bad;
        do_reset();
        model_reset(CD0);
        cnt_err = 0; ovf_err = 0;
        fork
            begin
                for (int k = 0; k < 600; k++) begin
                    we0  = ($urandom_range(0, 9) == 0);
                    rwd0 = 16'($urandom);
                    model_step(we0, rwd0);
                    @(negedge clk);
                    if (int'(cnt0) != m_q.size()) cnt_err++;
                    if (ovf0 !== m_ovf) ovf_err++;
                end
                we0 = 1'b0;
            end
            receive_all(0, 200);
        join
        n_checks++;
        if (cnt_err !== 0) begin n_fail++; $display("FAIL random_cnt: %0d cycles off, want 0", cnt_err); end
        n_checks++;
        if (ovf_err !== 0) begin n_fail++; $display("FAIL random_ovf: %0d cycles off, want 0", ovf_err); end
        n_checks++;
        if (rx_words.size() !== m_acc.size()) begin
            n_fail++;
            $display("FAIL random_rx_count: got %0d want %0d", rx_words.size(), m_acc.size());
        end
        bad = 0;
        foreach (rx_words[i]) if (i < m_acc.size() && rx_words[i] !== m_acc[i]) bad++;
        n_checks++;
        if (bad !== 0 || rx_glitch !== 0) begin
            n_fail++;
            $display("FAIL random_rx_data: %0d wrong %0d glitches want 0 0", bad, rx_glitch);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_spaced();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
